// File: rtl/ctrl_decode_pipe.sv
// rtl/ctrl_decode_pipe.sv - MIPS control decode with registered ID/EX stage, load-use/HI-LO stalls and flush
module ctrl_decode_pipe #(
  parameter bit BNE_EN  = 1'b1,
  parameter bit MD_EN   = 1'b1,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] instr,
  output logic        in_ready,
  input  logic        ex_memrd,
  input  logic [4:0]  ex_rt,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  pc_src,
  output logic        branch,
  output logic        reg_write,
  output logic [1:0]  reg_dst,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_to_reg,
  output logic        alu_src1,
  output logic        alu_src2,
  output logic        ext_op,
  output logic        lu_op,
  output logic [3:0]  alu_op,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [15:0] imm,
  output logic        illegal,
  output logic        md_busy
);

  typedef struct packed {
    logic [1:0] pcSrc;
    logic       branch;
    logic       regWrite;
    logic [1:0] regDst;
    logic       memRead;
    logic       memWrite;
    logic [1:0] memToReg;
    logic       aluSrc1;
    logic       aluSrc2;
    logic       extOp;
    logic       luOp;
    logic [3:0] aluOp;
  } ctrlT;

  localparam logic [3:0] mulLat = 4'(MUL_LAT);
  localparam logic [3:0] divLat = 4'(DIV_LAT);

  logic [5:0] op;
  logic [5:0] fn;
  ctrlT       dec;
  logic       illegalDec;
  logic       isMul;
  logic       isDiv;
  logic       isMdInstr;
  logic       loadUse;
  logic       mdHold;
  logic       accept;

  ctrlT       ctrlQ;
  logic       validQ;
  logic       illegalQ;
  logic [3:0] mdCnt;
  logic [4:0] rsQ;
  logic [4:0] rtQ;
  logic [4:0] rdQ;
  logic [4:0] shamtQ;
  logic [15:0] immQ;

  assign op = instr[31:26];
  assign fn = instr[5:0];

  always_comb begin
    dec          = '0;
    illegalDec   = 1'b0;
    isMul        = 1'b0;
    isDiv        = 1'b0;
    dec.aluOp[3] = op[0];
    case (op)
      6'h00: begin
        dec.regDst   = 2'b01;
        dec.aluOp    = 4'b0010;
        dec.regWrite = 1'b1;
        case (fn)
          6'h08: begin
            dec.pcSrc    = 2'b11;
            dec.regWrite = 1'b0;
          end
          6'h09: begin
            dec.pcSrc    = 2'b11;
            dec.regDst   = 2'b10;
            dec.memToReg = 2'b10;
          end
          6'h00, 6'h02, 6'h03: dec.aluSrc1 = 1'b1;
          6'h10, 6'h12: illegalDec = ~MD_EN;
          6'h18, 6'h19: begin
            dec.regWrite = 1'b0;
            isMul        = MD_EN;
            illegalDec   = ~MD_EN;
          end
          6'h1A, 6'h1B: begin
            dec.regWrite = 1'b0;
            isDiv        = MD_EN;
            illegalDec   = ~MD_EN;
          end
          default: ;
        endcase
      end
      6'h23: begin
        dec.memRead  = 1'b1;
        dec.memToReg = 2'b01;
        dec.aluSrc2  = 1'b1;
        dec.extOp    = 1'b1;
        dec.regWrite = 1'b1;
      end
      6'h2B: begin
        dec.memWrite = 1'b1;
        dec.aluSrc2  = 1'b1;
        dec.extOp    = 1'b1;
      end
      6'h0F: begin
        dec.luOp     = 1'b1;
        dec.aluSrc2  = 1'b1;
        dec.regWrite = 1'b1;
      end
      6'h08, 6'h09: begin
        dec.aluSrc2  = 1'b1;
        dec.extOp    = 1'b1;
        dec.regWrite = 1'b1;
      end
      6'h0C: begin
        dec.aluOp[2:0] = 3'b100;
        dec.aluSrc2    = 1'b1;
        dec.regWrite   = 1'b1;
      end
      6'h0A: begin
        dec.aluOp[2:0] = 3'b101;
        dec.extOp      = 1'b1;
        dec.aluSrc2    = 1'b1;
        dec.regWrite   = 1'b1;
      end
      6'h0B: begin
        dec.aluOp[2:0] = 3'b101;
        dec.aluSrc2    = 1'b1;
        dec.regWrite   = 1'b1;
      end
      6'h04: begin
        dec.branch = 1'b1;
        dec.extOp  = 1'b1;
        dec.aluOp  = 4'b0001;
      end
      6'h05: begin
        if (BNE_EN) begin
          dec.branch = 1'b1;
          dec.extOp  = 1'b1;
          dec.aluOp  = 4'b1001;
        end else begin
          illegalDec = 1'b1;
        end
      end
      6'h02: dec.pcSrc = 2'b01;
      6'h03: begin
        dec.pcSrc    = 2'b01;
        dec.regDst   = 2'b10;
        dec.memToReg = 2'b10;
        dec.regWrite = 1'b1;
      end
      default: illegalDec = 1'b1;
    endcase
  end

  // HI/LO consumers and producers both wait for a running mult/div
  assign isMdInstr = (op == 6'h00) &&
                     ((fn == 6'h10) || (fn == 6'h12) || (fn[5:2] == 4'b0110));
  assign loadUse   = ex_memrd && (ex_rt != 5'd0) &&
                     ((ex_rt == instr[25:21]) || (ex_rt == instr[20:16]));
  assign mdHold    = MD_EN && md_busy && isMdInstr;
  assign in_ready  = ~(loadUse | mdHold) & (~validQ | out_ready);
  assign accept    = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      validQ   <= 1'b0;
      ctrlQ    <= '0;
      illegalQ <= 1'b0;
      mdCnt    <= 4'd0;
      rsQ      <= 5'd0;
      rtQ      <= 5'd0;
      rdQ      <= 5'd0;
      shamtQ   <= 5'd0;
      immQ     <= 16'd0;
    end else begin
      illegalQ <= accept & illegalDec & ~flush;
      // Bubbles always carry a zero control word so no write can leak into EX
      if (flush) begin
        validQ <= 1'b0;
        ctrlQ  <= '0;
      end else if (accept) begin
        validQ <= ~illegalDec;
        ctrlQ  <= illegalDec ? '0 : dec;
        rsQ    <= instr[25:21];
        rtQ    <= instr[20:16];
        rdQ    <= instr[15:11];
        shamtQ <= instr[10:6];
        immQ   <= instr[15:0];
      end else if (out_ready) begin
        validQ <= 1'b0;
        ctrlQ  <= '0;
      end
      if (accept && !flush && isMul) begin
        mdCnt <= mulLat;
      end else if (accept && !flush && isDiv) begin
        mdCnt <= divLat;
      end else if (mdCnt != 4'd0) begin
        mdCnt <= mdCnt - 4'd1;
      end
    end
  end

  assign out_valid  = validQ;
  assign pc_src     = ctrlQ.pcSrc;
  assign branch     = ctrlQ.branch;
  assign reg_write  = ctrlQ.regWrite;
  assign reg_dst    = ctrlQ.regDst;
  assign mem_read   = ctrlQ.memRead;
  assign mem_write  = ctrlQ.memWrite;
  assign mem_to_reg = ctrlQ.memToReg;
  assign alu_src1   = ctrlQ.aluSrc1;
  assign alu_src2   = ctrlQ.aluSrc2;
  assign ext_op     = ctrlQ.extOp;
  assign lu_op      = ctrlQ.luOp;
  assign alu_op     = ctrlQ.aluOp;
  assign rs         = rsQ;
  assign rt         = rtQ;
  assign rd         = rdQ;
  assign shamt      = shamtQ;
  assign imm        = immQ;
  assign illegal    = illegalQ;
  assign md_busy    = (mdCnt != 4'd0);

endmodule
